key_event_ctrl: RTL and testbench
=================================

# key_event_ctrl

Multi-channel key debouncer and event generator: N raw pushbutton inputs are synchronised and debounced independently, and each channel emits one-cycle press, release, long-press and auto-repeat pulses plus a debounced level. It sits between the board key pins and the UI/menu control logic, replacing per-key single-pulse debouncers with one parametrised block.

## Interface
- NUM_KEYS, 4, number of independent key channels (1..32)
- ACTIVE_LOW, 1, 1: key_in low = pressed; 0: high = pressed
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles needed to accept a level change (10 ms @ 100 MHz); >= 2
- LONG_CYCLES, 100_000_000, hold time after accepted press before long-press event (1 s); >= 1
- REPEAT_CYCLES, 20_000_000, auto-repeat period after long-press (200 ms); >= 1
- REPEAT_EN, 1, 1 enables auto-repeat pulses; 0 suppresses them
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- key_in  in  NUM_KEYS  raw asynchronous key pins
- key_down  out  NUM_KEYS  debounced level, 1 = pressed
- key_press  out  NUM_KEYS  one-cycle pulse on accepted press
- key_release  out  NUM_KEYS  one-cycle pulse on accepted release
- key_long  out  NUM_KEYS  one-cycle pulse when held LONG_CYCLES
- key_repeat  out  NUM_KEYS  one-cycle pulse every REPEAT_CYCLES after key_long while held
- any_event  out  1  OR of all four pulse vectors, registered alongside them

## Operation
- Per channel: key_in normalised to active-high (inverted if ACTIVE_LOW), then two-flop synchroniser; synchroniser resets to "released".
- Debounce: counter increments each cycle the synchronised level differs from debounced state; clears in any cycle they match (bounce restarts count). On the D-th consecutive mismatch (D = DEBOUNCE_CYCLES) state flips and counter clears.
- Flip released->pressed: key_press pulses; hold counter cleared. Flip pressed->released: key_release pulses; hold/repeat tracking cleared.
- Hold counter increments every cycle while pressed. When it reaches LONG_CYCLES: key_long pulses once; repeat phase entered.
- Repeat phase: repeat counter pulses key_repeat every REPEAT_CYCLES cycles (first one REPEAT_CYCLES after key_long) until release. REPEAT_EN=0: no key_repeat ever.
- Counters saturate/stop; no wrap-around can produce a second key_long during one press.
- Release before LONG_CYCLES: key_release only, no key_long. Release in same cycle a long/repeat would fire: release wins, long/repeat suppressed.
- Channels fully independent; several bits of any vector may pulse in the same cycle.
- Counter widths: $clog2(param+1) each.

## Timing
- All outputs registered; reset value of every output 0 (key_down 0 = released).
- Latency, bounce-free input, edge 0 = first clk edge sampling new level: state flips at edge D+1; key_down and key_press/key_release high after edge D+2, low after edge D+3.
- key_long high exactly LONG_CYCLES cycles after key_press; repeat pulses at LONG_CYCLES + k*REPEAT_CYCLES, k >= 1.
- Pulses are exactly one cycle wide; any_event coincident with them.
- rst_n assertion mid-operation: all state, counters and outputs return to reset values immediately; held key after reset release is re-detected as a fresh press (key_press after D+2 cycles).

## Structure
- Shared package key_pkg: event-type enum (PRESS, RELEASE, LONG, REPEAT) and default timing constants for 100 MHz.
- Sub-module key_event_chan: one channel (sync, debounce, hold/repeat counters, pulse regs); top generates NUM_KEYS instances and ORs any_event.
- Parameter legality checked at elaboration ($error on DEBOUNCE_CYCLES < 2 etc.).

## Test plan
- NUM_KEYS=2, D=4, ACTIVE_LOW=1: key_in[0] 1->0 clean -> key_press[0] high one cycle after edge 6, key_down[0]=1; key_in[1] unaffected.
- Bounce: key_in[0] low 3 cycles, high 1, low stable -> exactly one key_press, D+2 edges after last falling transition; no key_release.
- LONG=20, REPEAT=5, REPEAT_EN=1, hold 40 cycles -> key_long 20 cycles after key_press, key_repeat at +25, +30, +35, +40; key_release after release.
- Same with REPEAT_EN=0 and a press released at hold 10 -> no key_long, no key_repeat, one key_release.
- Both keys pressed same cycle -> key_press=2'b11 in one cycle, any_event=1 one cycle.
- rst_n pulsed while key held in repeat phase -> all outputs 0 during reset; after release key_press re-fires at D+2, repeat sequence restarts.

Source files
------------

// File: rtl/key_pkg.sv
// Shared types and default timing constants for the key event controller.
package key_pkg;

  // Event kinds; the value doubles as the bit index in per-channel event vectors.
  typedef enum logic [1:0] {
    EV_PRESS   = 2'd0,
    EV_RELEASE = 2'd1,
    EV_LONG    = 2'd2,
    EV_REPEAT  = 2'd3
  } key_event_e;

  localparam int unsigned NUM_EVENTS = 4;

  // Reference system clock for the default timing constants.
  localparam int unsigned CLK_HZ = 100_000_000;

  // Milliseconds to clock cycles at CLK_HZ.
  function automatic int unsigned ms_to_cycles(input int unsigned ms);
    return ms * (CLK_HZ / 1000);
  endfunction

  localparam int unsigned DEF_DEBOUNCE_CYCLES = ms_to_cycles(10);
  localparam int unsigned DEF_LONG_CYCLES     = ms_to_cycles(1000);
  localparam int unsigned DEF_REPEAT_CYCLES   = ms_to_cycles(200);

endpackage

// File: rtl/key_event_chan.sv
// One key channel: synchroniser, debouncer, hold/repeat timing and
// registered event pulses. Events are produced in an internal stage and
// then registered once more onto the outputs.
module key_event_chan
  import key_pkg::*;
#(
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
  parameter bit          REPEAT_EN       = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  key_raw_i,
  output logic                  down_o,
  output logic [NUM_EVENTS-1:0] event_o,
  output logic                  event_any_o
);

  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
  localparam int REP_W  = $clog2(REPEAT_CYCLES + 1);

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

  // Raw pin normalised so that 1 always means pressed.
  logic key_norm;
  assign key_norm = ACTIVE_LOW ? ~key_raw_i : key_raw_i;

  logic                  sync1_q, sync2_q;
  logic                  state_q, state_d;
  logic [DEB_W-1:0]      deb_cnt_q, deb_cnt_d;
  logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d;
  logic                  rep_phase_q, rep_phase_d;
  logic [REP_W-1:0]      rep_cnt_q, rep_cnt_d;
  logic [NUM_EVENTS-1:0] ev_q, ev_d;
  logic                  flip;
  logic                  down_q;
  logic [NUM_EVENTS-1:0] event_q;

  // Two-flop synchroniser; resets to the released level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= key_norm;
      sync2_q <= sync1_q;
    end
  end

  // Debounce, hold and repeat next-state; events raised here are one cycle wide.
  always_comb begin
    state_d     = state_q;
    deb_cnt_d   = deb_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    rep_phase_d = rep_phase_q;
    rep_cnt_d   = rep_cnt_q;
    ev_d        = '0;
    flip        = 1'b0;

    // Any matching cycle restarts the count, so bounces never accumulate.
    if (sync2_q != state_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        flip      = 1'b1;
        state_d   = sync2_q;
        deb_cnt_d = '0;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end else begin
      deb_cnt_d = '0;
    end

    // A flip takes priority, so a release swallows a long/repeat due the same cycle.
    if (flip) begin
      ev_d[EV_PRESS]   = ~state_q;
      ev_d[EV_RELEASE] = state_q;
      hold_cnt_d       = '0;
      rep_phase_d      = 1'b0;
      rep_cnt_d        = '0;
    end else if (state_q) begin
      if (!rep_phase_q) begin
        // The hold counter parks at its maximum once the long event fires,
        // and only a flip clears the repeat phase, so long fires once per press.
        if (hold_cnt_q == HOLD_LAST) begin
          ev_d[EV_LONG] = 1'b1;
          hold_cnt_d    = HOLD_MAX;
          rep_phase_d   = 1'b1;
          rep_cnt_d     = '0;
        end else if (hold_cnt_q != HOLD_MAX) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end else begin
        if (rep_cnt_q == REP_LAST) begin
          ev_d[EV_REPEAT] = REPEAT_EN;
          rep_cnt_d       = '0;
        end else begin
          rep_cnt_d = rep_cnt_q + 1'b1;
        end
      end
    end
  end

  // State stage: debounced level, counters and raw event flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= 1'b0;
      deb_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      rep_phase_q <= 1'b0;
      rep_cnt_q   <= '0;
      ev_q        <= '0;
    end else begin
      state_q     <= state_d;
      deb_cnt_q   <= deb_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      rep_phase_q <= rep_phase_d;
      rep_cnt_q   <= rep_cnt_d;
      ev_q        <= ev_d;
    end
  end

  // Output stage: level and pulses registered together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      down_q  <= 1'b0;
      event_q <= '0;
    end else begin
      down_q  <= state_q;
      event_q <= ev_q;
    end
  end

  assign down_o      = down_q;
  assign event_o     = event_q;
  // Taken from the state stage so the top can register the OR in step with event_o.
  assign event_any_o = |ev_q;

endmodule

// File: rtl/key_event_ctrl.sv
// Multi-channel key debouncer and event generator: one key_event_chan per
// key plus a registered any_event summary aligned with the pulse outputs.
module key_event_ctrl
  import key_pkg::*;
#(
  parameter int unsigned NUM_KEYS        = 4,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
  parameter bit          REPEAT_EN       = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_down,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long,
  output logic [NUM_KEYS-1:0] key_repeat,
  output logic                any_event
);

  if (NUM_KEYS < 1 || NUM_KEYS > 32) begin : g_err_num_keys
    $error("key_event_ctrl: NUM_KEYS must be within 1..32");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_err_debounce
    $error("key_event_ctrl: DEBOUNCE_CYCLES must be >= 2");
  end
  if (LONG_CYCLES < 1) begin : g_err_long
    $error("key_event_ctrl: LONG_CYCLES must be >= 1");
  end
  if (REPEAT_CYCLES < 1) begin : g_err_repeat
    $error("key_event_ctrl: REPEAT_CYCLES must be >= 1");
  end

  logic [NUM_EVENTS-1:0] chan_ev [NUM_KEYS];
  logic [NUM_KEYS-1:0]   chan_any;
  logic                  any_event_q;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_chan
    key_event_chan #(
      .ACTIVE_LOW      (ACTIVE_LOW),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES),
      .REPEAT_EN       (REPEAT_EN)
    ) u_chan (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_raw_i   (key_in[g]),
      .down_o      (key_down[g]),
      .event_o     (chan_ev[g]),
      .event_any_o (chan_any[g])
    );

    assign key_press[g]   = chan_ev[g][EV_PRESS];
    assign key_release[g] = chan_ev[g][EV_RELEASE];
    assign key_long[g]    = chan_ev[g][EV_LONG];
    assign key_repeat[g]  = chan_ev[g][EV_REPEAT];
  end

  // Summary flag registered on the same edge as the channel pulse outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      any_event_q <= 1'b0;
    end else begin
      any_event_q <= |chan_any;
    end
  end

  assign any_event = any_event_q;

endmodule

// File: tb/tb_key_event_ctrl.sv
// Bench for key_event_ctrl: two instances (auto-repeat on / off), a
// scoreboard of expected pulses keyed by cycle, and per-scenario tasks.
module tb_key_event_ctrl;
  import key_pkg::*;

  localparam int D = 4;
  localparam int L = 20;
  localparam int R = 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] key_in, key_in_nr;
  logic [1:0] down, press, rel, lng, rep;
  logic       any;
  logic [1:0] down_nr, press_nr, rel_nr, lng_nr, rep_nr;
  logic       any_nr;

  key_event_ctrl #(
    .NUM_KEYS(2), .ACTIVE_LOW(1'b1), .DEBOUNCE_CYCLES(D),
    .LONG_CYCLES(L), .REPEAT_CYCLES(R), .REPEAT_EN(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_down(down),
    .key_press(press), .key_release(rel), .key_long(lng),
    .key_repeat(rep), .any_event(any)
  );

  key_event_ctrl #(
    .NUM_KEYS(2), .ACTIVE_LOW(1'b1), .DEBOUNCE_CYCLES(D),
    .LONG_CYCLES(L), .REPEAT_CYCLES(R), .REPEAT_EN(1'b0)
  ) dut_nr (
    .clk(clk), .rst_n(rst_n), .key_in(key_in_nr), .key_down(down_nr),
    .key_press(press_nr), .key_release(rel_nr), .key_long(lng_nr),
    .key_repeat(rep_nr), .any_event(any_nr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int         cyc;
    int         dut;
    key_event_e kind;
    logic [1:0] mask;
  } exp_t;
  exp_t exp_q[$];

  task automatic push_exp(input int c, input int d, input key_event_e k, input logic [1:0] m);
    exp_t e;
    e.cyc = c; e.dut = d; e.kind = k; e.mask = m;
    exp_q.push_back(e);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Scoreboard: every cycle, collect expectations due now and compare pulses.
  logic [7:0] mon_exp [2];
  logic [7:0] mon_obs [2];
  logic       mon_any [2];
  always @(negedge clk) begin
    mon_exp[0] = '0;
    mon_exp[1] = '0;
    mon_obs[0] = {rep, lng, rel, press};
    mon_obs[1] = {rep_nr, lng_nr, rel_nr, press_nr};
    mon_any[0] = any;
    mon_any[1] = any_nr;
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].cyc == cyc) begin
        mon_exp[exp_q[i].dut][int'(exp_q[i].kind)*2 +: 2] =
          mon_exp[exp_q[i].dut][int'(exp_q[i].kind)*2 +: 2] | exp_q[i].mask;
        exp_q.delete(i);
      end else if (exp_q[i].cyc < cyc) begin
        checks++; failures++;
        $display("FAIL stale_expectation cyc=%0d due=%0d", cyc, exp_q[i].cyc);
        exp_q.delete(i);
      end
    end
    for (int d = 0; d < 2; d++) begin
      if (mon_obs[d] != 8'h00 || mon_exp[d] != 8'h00) begin
        checks++;
        if (mon_obs[d] !== mon_exp[d]) begin
          failures++;
          $display("FAIL pulses dut%0d cyc=%0d got {rep,long,rel,press}=%b expected=%b",
                   d, cyc, mon_obs[d], mon_exp[d]);
        end
      end
      if (mon_any[d] !== 1'b0 || mon_exp[d] != 8'h00) begin
        checks++;
        if (mon_any[d] !== (mon_exp[d] != 8'h00)) begin
          failures++;
          $display("FAIL any_event dut%0d cyc=%0d got=%b expected=%b",
                   d, cyc, mon_any[d], (mon_exp[d] != 8'h00));
        end
      end
    end
  end

  // Press key 0 of one instance, release it rel_off cycles after key_press,
  // and schedule the pulses a correct design must produce.
  task automatic press_hold(input int d, input int rel_off);
    int t0, p, rel_t;
    logic [1:0] lvl;
    @(negedge clk); #1;
    if (d == 0) key_in[0] = 1'b0; else key_in_nr[0] = 1'b0;
    t0 = cyc + 1;
    p = t0 + D + 2;
    rel_t = p + rel_off + 1 + D + 2;
    push_exp(p, d, EV_PRESS, 2'b01);
    if (p + L < rel_t) push_exp(p + L, d, EV_LONG, 2'b01);
    if (d == 0)
      for (int k = 1; p + L + k*R < rel_t; k++) push_exp(p + L + k*R, d, EV_REPEAT, 2'b01);
    push_exp(rel_t, d, EV_RELEASE, 2'b01);
    wait_until(p);
    lvl = (d == 0) ? down : down_nr;
    checks++;
    if (lvl !== 2'b01) begin
      failures++;
      $display("FAIL key_down_pressed dut%0d got=%b expected=01", d, lvl);
    end
    wait_until(p + rel_off); #1;
    if (d == 0) key_in[0] = 1'b1; else key_in_nr[0] = 1'b1;
    wait_until(rel_t + 1);
    lvl = (d == 0) ? down : down_nr;
    checks++;
    if (lvl !== 2'b00) begin
      failures++;
      $display("FAIL key_down_released dut%0d got=%b expected=00", d, lvl);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({down, press, rel, lng, rep, any} !== 11'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b expected=0", {down, press, rel, lng, rep, any});
    end
    checks++;
    if ({down_nr, press_nr, rel_nr, lng_nr, rep_nr, any_nr} !== 11'b0) begin
      failures++;
      $display("FAIL reset_outputs_nr got=%b expected=0",
               {down_nr, press_nr, rel_nr, lng_nr, rep_nr, any_nr});
    end
    #1 rst_n = 1'b1;
    repeat (D + 4) @(negedge clk);
    checks++;
    if (down !== 2'b00) begin
      failures++;
      $display("FAIL idle_after_reset key_down got=%b expected=00", down);
    end
  endtask

  task automatic test_clean_press();
    press_hold(0, 2);
  endtask

  task automatic test_bounce();
    int tl, rel_t;
    @(negedge clk); #1;
    key_in[0] = 1'b0;
    repeat (3) @(negedge clk);
    #1 key_in[0] = 1'b1;
    @(negedge clk); #1;
    key_in[0] = 1'b0;
    tl = cyc + 1;
    push_exp(tl + D + 2, 0, EV_PRESS, 2'b01);
    wait_until(tl + D + 2);
    checks++;
    if (down !== 2'b01) begin
      failures++;
      $display("FAIL bounce_key_down got=%b expected=01", down);
    end
    wait_until(tl + D + 3); #1;
    key_in[0] = 1'b1;
    rel_t = tl + D + 4 + D + 2;
    push_exp(rel_t, 0, EV_RELEASE, 2'b01);
    wait_until(rel_t + 1);
  endtask

  task automatic test_long_repeat();
    press_hold(0, 36);
  endtask

  task automatic test_release_wins();
    press_hold(0, L - D - 3);
    press_hold(0, L + 2*R - D - 3);
  endtask

  task automatic test_no_repeat();
    press_hold(1, 36);
    press_hold(1, 10 - D - 3);
  endtask

  task automatic test_both();
    int p, rel_t;
    @(negedge clk); #1;
    key_in = 2'b00;
    p = cyc + 1 + D + 2;
    push_exp(p, 0, EV_PRESS, 2'b11);
    wait_until(p);
    checks++;
    if (down !== 2'b11) begin
      failures++;
      $display("FAIL both_key_down got=%b expected=11", down);
    end
    wait_until(p + 2); #1;
    key_in = 2'b11;
    rel_t = p + 3 + D + 2;
    push_exp(rel_t, 0, EV_RELEASE, 2'b11);
    wait_until(rel_t + 1);
    checks++;
    if (down !== 2'b00) begin
      failures++;
      $display("FAIL both_key_up got=%b expected=00", down);
    end
  endtask

  task automatic test_reset_mid();
    int p, q, p2, rel_t;
    @(negedge clk); #1;
    key_in[0] = 1'b0;
    p = cyc + 1 + D + 2;
    push_exp(p, 0, EV_PRESS, 2'b01);
    push_exp(p + L, 0, EV_LONG, 2'b01);
    push_exp(p + L + R, 0, EV_REPEAT, 2'b01);
    wait_until(p + L + R + 2); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({down, press, rel, lng, rep, any} !== 11'b0) begin
      failures++;
      $display("FAIL reset_immediate got=%b expected=0", {down, press, rel, lng, rep, any});
    end
    wait_until(p + L + R + 5);
    checks++;
    if ({down, press, rel, lng, rep, any} !== 11'b0) begin
      failures++;
      $display("FAIL reset_held got=%b expected=0", {down, press, rel, lng, rep, any});
    end
    #1 rst_n = 1'b1;
    q = cyc;
    p2 = q + 1 + D + 2;
    rel_t = p2 + 26 + 1 + D + 2;
    push_exp(p2, 0, EV_PRESS, 2'b01);
    push_exp(p2 + L, 0, EV_LONG, 2'b01);
    for (int k = 1; p2 + L + k*R < rel_t; k++) push_exp(p2 + L + k*R, 0, EV_REPEAT, 2'b01);
    push_exp(rel_t, 0, EV_RELEASE, 2'b01);
    wait_until(p2 + 26); #1;
    key_in[0] = 1'b1;
    wait_until(rel_t + 2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d expected completion earlier", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    key_in = 2'b11;
    key_in_nr = 2'b11;
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_repeat();
    test_release_wins();
    test_no_repeat();
    test_both();
    test_reset_mid();
    repeat (5) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drained got=%0d pending expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
